// File: rtl/ex_stage.sv
// MiniRiscV execute stage: ALU, store data and registered memory-stage bundle.
// Optional multiply/divide support (iterative radix-2 divider) is built when EX_MULDIV_EN is defined.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        Flush,
    input  logic        InValid,
    input  logic [4:0]  AluOp,
    input  logic [31:0] Rs1Val,
    input  logic [31:0] Rs2Val,
    input  logic [31:0] Imm,
    input  logic        UseImm,
    input  logic [31:0] Pc,
    input  logic        MemReadIn,
    input  logic        MemWriteIn,
    input  logic        MemtoRegIn,
    input  logic        RegWriteIn,
    input  logic [4:0]  RdIn,
    output logic        Busy,
    output logic        OutValid,
    output logic [31:0] ALUResult,
    output logic [31:0] DataIn,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic [4:0]  Rd
);

    logic [31:0] op_b_s;
    logic [31:0] alu_s;
    logic        accept_s;

    assign op_b_s   = UseImm ? Imm : Rs2Val;
    assign accept_s = InValid & ~Busy & ~Flush;

`ifdef EX_MULDIV_EN
    localparam int DIV_CYCLES = 32;

    typedef enum logic [0:0] {IDLE = 1'b0, DIV = 1'b1} state_t;

    state_t      state_r;
    logic [4:0]  cnt_r;
    logic [31:0] quo_r;
    logic [31:0] rem_r;
    logic [31:0] dvs_r;
    logic [31:0] dvd_raw_r;
    logic [31:0] din_r;
    logic        q_neg_r;
    logic        r_neg_r;
    logic        is_rem_r;
    logic        dvs_zero_r;
    logic [3:0]  ctl_r;
    logic [4:0]  rd_r;
    logic [63:0] mul_a_s;
    logic [63:0] mul_b_s;
    logic [63:0] prod_s;
    logic [32:0] trial_s;
    logic        ge_s;
    logic [31:0] quo_nx_s;
    logic [31:0] rem_nx_s;
    logic [31:0] div_res_s;
    logic        is_div_s;
    logic        div_signed_s;
    logic        neg_a_s;
    logic        neg_b_s;

    assign Busy         = (state_r == DIV);
    assign is_div_s     = (AluOp >= 5'd20) && (AluOp <= 5'd23);
    assign div_signed_s = (AluOp == 5'd20) || (AluOp == 5'd22);
    assign neg_a_s      = div_signed_s & Rs1Val[31];
    assign neg_b_s      = div_signed_s & op_b_s[31];

    // 64-bit product; A is zero-extended only for MULHU, B sign-extended only for MUL/MULH
    always_comb begin
        mul_a_s = {{32{Rs1Val[31] & (AluOp != 5'd19)}}, Rs1Val};
        mul_b_s = {{32{op_b_s[31] & ((AluOp == 5'd16) || (AluOp == 5'd17))}}, op_b_s};
        prod_s  = mul_a_s * mul_b_s;
    end

    // One restoring step on magnitudes plus the sign-corrected / special-case result
    always_comb begin
        trial_s  = {rem_r, quo_r[31]} - {1'b0, dvs_r};
        ge_s     = ~trial_s[32];
        quo_nx_s = {quo_r[30:0], ge_s};
        if (ge_s) begin
            rem_nx_s = trial_s[31:0];
        end else begin
            rem_nx_s = {rem_r[30:0], quo_r[31]};
        end
        if (dvs_zero_r) begin
            div_res_s = is_rem_r ? dvd_raw_r : 32'hFFFF_FFFF;
        end else if (is_rem_r) begin
            div_res_s = r_neg_r ? (32'd0 - rem_nx_s) : rem_nx_s;
        end else begin
            div_res_s = q_neg_r ? (32'd0 - quo_nx_s) : quo_nx_s;
        end
    end
`else
    assign Busy = 1'b0;
`endif

    // Single-cycle ALU result selection
    always_comb begin
        alu_s = 32'd0;
        case (AluOp)
            5'd0:    alu_s = Rs1Val + op_b_s;
            5'd1:    alu_s = Rs1Val - op_b_s;
            5'd2:    alu_s = Rs1Val << op_b_s[4:0];
            5'd3:    alu_s = {31'd0, $signed(Rs1Val) < $signed(op_b_s)};
            5'd4:    alu_s = {31'd0, Rs1Val < op_b_s};
            5'd5:    alu_s = Rs1Val ^ op_b_s;
            5'd6:    alu_s = Rs1Val >> op_b_s[4:0];
            5'd7:    alu_s = $signed(Rs1Val) >>> op_b_s[4:0];
            5'd8:    alu_s = Rs1Val | op_b_s;
            5'd9:    alu_s = Rs1Val & op_b_s;
            5'd10:   alu_s = op_b_s;
            5'd11:   alu_s = Pc + op_b_s;
            5'd12:   alu_s = Pc + 32'd4;
`ifdef EX_MULDIV_EN
            5'd16:   alu_s = prod_s[31:0];
            5'd17:   alu_s = prod_s[63:32];
            5'd18:   alu_s = prod_s[63:32];
            5'd19:   alu_s = prod_s[63:32];
`endif
            default: alu_s = 32'd0;
        endcase
    end

    // Output bundle register and divider FSM; every edge defaults to a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            OutValid  <= 1'b0;
            ALUResult <= 32'd0;
            DataIn    <= 32'd0;
            MemRead   <= 1'b0;
            MemWrite  <= 1'b0;
            MemtoReg  <= 1'b0;
            RegWrite  <= 1'b0;
            Rd        <= 5'd0;
`ifdef EX_MULDIV_EN
            state_r    <= IDLE;
            cnt_r      <= 5'd0;
            quo_r      <= 32'd0;
            rem_r      <= 32'd0;
            dvs_r      <= 32'd0;
            dvd_raw_r  <= 32'd0;
            din_r      <= 32'd0;
            q_neg_r    <= 1'b0;
            r_neg_r    <= 1'b0;
            is_rem_r   <= 1'b0;
            dvs_zero_r <= 1'b0;
            ctl_r      <= 4'd0;
            rd_r       <= 5'd0;
`endif
        end else begin
            OutValid  <= 1'b0;
            ALUResult <= 32'd0;
            DataIn    <= 32'd0;
            MemRead   <= 1'b0;
            MemWrite  <= 1'b0;
            MemtoReg  <= 1'b0;
            RegWrite  <= 1'b0;
            Rd        <= 5'd0;
`ifdef EX_MULDIV_EN
            if (Flush) begin
                state_r <= IDLE;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (accept_s && is_div_s) begin
                            quo_r      <= neg_a_s ? (32'd0 - Rs1Val) : Rs1Val;
                            rem_r      <= 32'd0;
                            dvs_r      <= neg_b_s ? (32'd0 - op_b_s) : op_b_s;
                            dvd_raw_r  <= Rs1Val;
                            din_r      <= Rs2Val;
                            q_neg_r    <= neg_a_s ^ neg_b_s;
                            r_neg_r    <= neg_a_s;
                            is_rem_r   <= AluOp[1];
                            dvs_zero_r <= (op_b_s == 32'd0);
                            ctl_r      <= {MemReadIn, MemWriteIn, MemtoRegIn, RegWriteIn};
                            rd_r       <= RdIn;
                            cnt_r      <= 5'(DIV_CYCLES - 1);
                            state_r    <= DIV;
                        end else if (accept_s) begin
                            OutValid  <= 1'b1;
                            ALUResult <= alu_s;
                            DataIn    <= Rs2Val;
                            {MemRead, MemWrite, MemtoReg, RegWrite} <= {MemReadIn, MemWriteIn, MemtoRegIn, RegWriteIn};
                            Rd        <= RdIn;
                        end
                    end
                    DIV: begin
                        quo_r <= quo_nx_s;
                        rem_r <= rem_nx_s;
                        if (cnt_r == 5'd0) begin
                            OutValid  <= 1'b1;
                            ALUResult <= div_res_s;
                            DataIn    <= din_r;
                            {MemRead, MemWrite, MemtoReg, RegWrite} <= ctl_r;
                            Rd        <= rd_r;
                            state_r   <= IDLE;
                        end else begin
                            cnt_r <= cnt_r - 5'd1;
                        end
                    end
                    default: state_r <= IDLE;
                endcase
            end
`else
            if (accept_s) begin
                OutValid  <= 1'b1;
                ALUResult <= alu_s;
                DataIn    <= Rs2Val;
                {MemRead, MemWrite, MemtoReg, RegWrite} <= {MemReadIn, MemWriteIn, MemtoRegIn, RegWriteIn};
                Rd        <= RdIn;
            end
`endif
        end
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage of the MiniRiscV pipeline, directly upstream of the memory stage. Takes decoded operands and control from decode, computes the ALU result, store data and memory controls, and registers them for the memory stage. The memory stage consumes ALUResult, DataIn, MemRead, MemWrite and MemtoReg. Single-cycle ops complete in one cycle. Divide and remainder run on an iterative radix-2 engine and stall decode via Busy.

Parameters:
DIV_CYCLES, 32, number of divider iterations; fixed at the operand width.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, synchronous, active-high
Flush  in  1  kill the in-flight/incoming op (branch redirect)
InValid  in  1  decode presents a valid instruction
AluOp  in  5  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB, 11 PC+B, 12 PC+4, 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU; others give result 0
Rs1Val  in  32  operand A
Rs2Val  in  32  register operand B; also the store data
Imm  in  32  immediate
UseImm  in  1  1: B=Imm, 0: B=Rs2Val
Pc  in  32  instruction PC
MemReadIn, MemWriteIn, MemtoRegIn, RegWriteIn  in  1 each  decode controls
RdIn  in  5  destination register
Busy  out  1  combinational; high while the divider is active; decode must hold
OutValid  out  1  registered; output bundle is a real instruction
ALUResult  out  32  registered result; also the memory address
DataIn  out  32  registered store data (Rs2Val)
MemRead, MemWrite, MemtoReg, RegWrite  out  1 each  registered controls
Rd  out  5  registered destination

Behaviour:
- Reset (rst=1 at an edge): all registered outputs 0; FSM goes to IDLE; Busy=0 from the next cycle.
- Accept condition is InValid & ~Busy & ~Flush.
- FSM states: IDLE and DIV.
- IDLE, accepted op with AluOp not in 20-23: outputs are loaded at that edge, so latency is 1. OutValid=1 and controls are copied from the inputs.
- IDLE, no accept: a bubble. OutValid, all four controls, ALUResult, DataIn and Rd are set to 0.
- IDLE, accepted op with AluOp in 20-23:
  - capture operands, sign info, Rd and controls;
  - load the counter with DIV_CYCLES-1 and go to DIV;
  - output a bubble at this edge.
- DIV: Busy=1. Each edge performs one restoring shift-subtract step on magnitudes and decrements the counter, with bubbles on the outputs.
- DIV, edge with counter==0: the final step is combined with sign correction. Load the result with OutValid=1, then return to IDLE.
  - An op accepted at edge T therefore has its result visible after edge T+DIV_CYCLES.
  - Busy is high for DIV_CYCLES cycles.
- Divide special cases (fixed latency regardless):
  - divisor 0: quotient 0xFFFFFFFF, remainder = dividend;
  - signed 0x80000000 / -1: quotient 0x80000000, remainder 0.
- Remainder sign follows the dividend; quotient sign is the XOR of the operand signs.
- Arithmetic rules:
  - all 32-bit, wrap-around, no overflow flags;
  - shift amount is B[4:0];
  - SLT/SLTU write 0 or 1;
  - MUL is the low 32 bits; MULH/MULHSU/MULHU are the high 32 bits of the 64-bit product (signed×signed, signed×unsigned, unsigned×unsigned), single-cycle.
- Flush has priority over everything except rst:
  - nothing is accepted that cycle;
  - any divide is aborted to IDLE;
  - outputs become a bubble at that edge;
  - Busy=0 the next cycle.
- InValid while Busy=1 is ignored; decode holds its bundle stable.

Optional Feature:
Macro EX_MULDIV_EN. When defined, ops 16-23 behave as specified above. When undefined, the multiplier and divider are not built: AluOp 16-23 act as unrecognised ops (result 0, 1-cycle latency, controls passed through), the DIV state is absent and Busy is tied to 0.

Test Plan:
- ADD, Rs1Val=0x7FFFFFFF, Rs2Val=1, UseImm=0 -> next cycle OutValid=1, ALUResult=0x80000000, DataIn=1.
- Load: ADD, Rs1Val=0x100, Imm=0xFFFFFFFC, UseImm=1, MemReadIn=MemtoRegIn=RegWriteIn=1, RdIn=5 -> ALUResult=0xFC, MemRead=MemtoReg=RegWrite=1, Rd=5; InValid=0 the following cycle -> all outputs 0.
- DIV: -100 / 7, accepted at edge T -> Busy high for 32 cycles, bubbles, then after T+32 ALUResult=0xFFFFFFF2 (-14); REM with the same operands gives 0xFFFFFFFE (-2).
- DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, with REM -> 0; each still takes 32 cycles.
- Flush asserted 10 cycles into a DIV -> next cycle Busy=0 and OutValid=0; no result ever appears; a following ADD 2+3 yields 5 at 1-cycle latency.
- EX_MULDIV_EN undefined: MUL 3×4 -> ALUResult=0, latency 1, Busy never asserts. Defined: MULHU 0xFFFFFFFF×2 -> ALUResult=1.
